// File: rtl/axi_bram2axis.sv
// Streams a contiguous BRAM region out as AXI4-Stream. Read latency is absorbed
// by a credit-managed FIFO so downstream backpressure never drops a word.
module axi_bram2axis #(
  parameter int AXI_DATA_WIDTH      = 128,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = 128,
  parameter int BRAM_DELAY          = 2,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           i_b2as_start,
  output logic                           o_b2as_done,
  input  logic [BRAM_ADDR_WIDTH-1:0]     i_b2as_bram_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2as_data_size_bytes,
  output logic                           o_b2as_rden,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_b2as_rdaddr,
  input  logic [BRAM_DATA_WIDTH-1:0]     i_b2as_rddata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                           m_axis_tlast
);

  localparam int SW         = AXI_XFER_SIZE_WIDTH;
  localparam int BYTES      = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = PW + 1;
  localparam int IW         = $clog2(BRAM_DELAY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [SW-1:0]              beats;
  logic [SW-1:0]              rd_remaining;
  logic [SW-1:0]              out_cnt;
  logic [SW-1:0]              size_beats;
  logic [BRAM_DELAY-1:0]      vld_sr;
  logic [IW-1:0]              inflight;
  logic [CW:0]                credit_used;
  logic [BRAM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              fifo_count;
  logic                       push;
  logic                       pop;

  // A partial final word still costs a full beat; the divide avoids overflow on huge sizes.
  assign size_beats = (i_b2as_data_size_bytes >> BYTE_SHIFT)
                    + SW'((i_b2as_data_size_bytes & SW'(BYTES - 1)) != '0);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_DELAY; i++) inflight += IW'(vld_sr[i]);
  end

  // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
  assign credit_used   = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign o_b2as_rden   = (state == RUN) && (rd_remaining != '0)
                      && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign o_b2as_rdaddr = addr;

  assign push          = vld_sr[BRAM_DELAY-1];
  assign m_axis_tvalid = (fifo_count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt == beats - SW'(1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      addr         <= '0;
      beats        <= '0;
      rd_remaining <= '0;
      out_cnt      <= '0;
      o_b2as_done  <= 1'b0;
    end else begin
      o_b2as_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_b2as_start) begin
            addr         <= i_b2as_bram_addr;
            beats        <= size_beats;
            rd_remaining <= size_beats;
            out_cnt      <= '0;
            if (size_beats == '0) begin
              state       <= DONE;
              o_b2as_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (o_b2as_rden) begin
            addr         <= addr + BRAM_ADDR_WIDTH'(1);
            rd_remaining <= rd_remaining - SW'(1);
          end
          if (pop) begin
            out_cnt <= out_cnt + SW'(1);
            if (m_axis_tlast) begin
              state       <= DONE;
              o_b2as_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) vld_sr <= '0;
    else        vld_sr <= (vld_sr << 1) | BRAM_DELAY'(o_b2as_rden);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; fifo_count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= i_b2as_rddata;
  end

endmodule
